// File: rtl/regfile_hilo_pkg.sv
// Shared writeback-to-regfile bus layout: width, field offsets and an unpacking helper.
// Consumed by regfile_hilo and by the WB stage that produces the bus.
package regfile_hilo_pkg;

  localparam int unsigned RF_AW = 5;
  localparam int unsigned RF_DW = 32;

  localparam int unsigned WB_TO_RF_WD = 104;

  localparam int unsigned RF_WDATA_LSB = 0;
  localparam int unsigned RF_WDATA_MSB = 31;
  localparam int unsigned RF_WADDR_LSB = 32;
  localparam int unsigned RF_WADDR_MSB = 36;
  localparam int unsigned RF_WE_BIT    = 37;
  localparam int unsigned HI_WDATA_LSB = 38;
  localparam int unsigned HI_WDATA_MSB = 69;
  localparam int unsigned HI_WE_BIT    = 70;
  localparam int unsigned LO_WDATA_LSB = 71;
  localparam int unsigned LO_WDATA_MSB = 102;
  localparam int unsigned LO_WE_BIT    = 103;

  typedef struct packed {
    logic             lo_we;
    logic [RF_DW-1:0] lo_wdata;
    logic             hi_we;
    logic [RF_DW-1:0] hi_wdata;
    logic             rf_we;
    logic [RF_AW-1:0] rf_waddr;
    logic [RF_DW-1:0] rf_wdata;
  } wb_to_rf_t;

  function automatic wb_to_rf_t unpack_wb_to_rf(input logic [WB_TO_RF_WD-1:0] bus);
    wb_to_rf_t f;
    f.rf_wdata = bus[RF_WDATA_MSB:RF_WDATA_LSB];
    f.rf_waddr = bus[RF_WADDR_MSB:RF_WADDR_LSB];
    f.rf_we    = bus[RF_WE_BIT];
    f.hi_wdata = bus[HI_WDATA_MSB:HI_WDATA_LSB];
    f.hi_we    = bus[HI_WE_BIT];
    f.lo_wdata = bus[LO_WDATA_MSB:LO_WDATA_LSB];
    f.lo_we    = bus[LO_WE_BIT];
    return f;
  endfunction

endpackage

// File: rtl/regfile_hilo_hilo_reg.sv
// HI/LO register pair with independent write enables and synchronous clear.
// REGFILE_BYPASS_EN: a same-cycle write is shown on the read outputs (suppressed during reset).
module hilo_reg #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hi_we,
  input  logic [DW-1:0] hi_wdata,
  input  logic          lo_we,
  input  logic [DW-1:0] lo_wdata,
  output logic [DW-1:0] hi_rdata,
  output logic [DW-1:0] lo_rdata
);

  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

  always_comb begin
    hi_rdata = hi_q;
    lo_rdata = lo_q;
`ifdef REGFILE_BYPASS_EN
    if (!rst && hi_we) hi_rdata = hi_wdata;
    if (!rst && lo_we) lo_rdata = lo_wdata;
`endif
  end

endmodule

// File: rtl/regfile_hilo.sv
// 32x32 GPR file ($0 reads zero) plus HI/LO, written from the WB bus, read combinationally.
// REGFILE_BYPASS_EN: write-first bypass of same-cycle writes onto the read ports.
module regfile_hilo
  import regfile_hilo_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
  input  logic [4:0]             raddr1,
  output logic [DW-1:0]          rdata1,
  input  logic [4:0]             raddr2,
  output logic [DW-1:0]          rdata2,
  output logic [DW-1:0]          hi_rdata,
  output logic [DW-1:0]          lo_rdata
);

  wb_to_rf_t wb;
  logic [DW-1:0] regs [NREG];

  assign wb = unpack_wb_to_rf(wb_to_rf_bus);

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (wb.rf_we && (wb.rf_waddr != '0)) begin
      regs[wb.rf_waddr] <= wb.rf_wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) begin
      rdata1 = regs[raddr1];
`ifdef REGFILE_BYPASS_EN
      if (!rst && wb.rf_we && (wb.rf_waddr == raddr1)) rdata1 = wb.rf_wdata;
`endif
    end
    if (raddr2 != '0) begin
      rdata2 = regs[raddr2];
`ifdef REGFILE_BYPASS_EN
      if (!rst && wb.rf_we && (wb.rf_waddr == raddr2)) rdata2 = wb.rf_wdata;
`endif
    end
  end

  hilo_reg #(
    .DW(DW)
  ) u_hilo_reg (
    .clk      (clk),
    .rst      (rst),
    .hi_we    (wb.hi_we),
    .hi_wdata (wb.hi_wdata),
    .lo_we    (wb.lo_we),
    .lo_wdata (wb.lo_wdata),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata)
  );

endmodule

// File: tb/tb_regfile_hilo.sv
// Directed and randomized checks of regfile_hilo against a small reference model.
// Honours REGFILE_BYPASS_EN in the expected values so either build can be checked.
module tb_regfile_hilo;

  logic         clk = 1'b0;
  logic         rst;
  logic [103:0] wb_to_rf_bus;
  logic [4:0]   raddr1, raddr2;
  logic [31:0]  rdata1, rdata2, hi_rdata, lo_rdata;

  logic        b_rf_we, b_hi_we, b_lo_we;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata, b_hi_wdata, b_lo_wdata;

  logic [31:0] m_regs [32];
  logic [31:0] m_hi, m_lo;

  int checks = 0;
  int failures = 0;

  assign wb_to_rf_bus = {b_lo_we, b_lo_wdata, b_hi_we, b_hi_wdata, b_rf_we, b_waddr, b_wdata};

  always #5 clk = ~clk;

  regfile_hilo #(
    .NREG(32),
    .DW  (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_to_rf_bus (wb_to_rf_bus),
    .raddr1       (raddr1),
    .rdata1       (rdata1),
    .raddr2       (raddr2),
    .rdata2       (rdata2),
    .hi_rdata     (hi_rdata),
    .lo_rdata     (lo_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    b_rf_we = 1'b0; b_waddr = '0; b_wdata = '0;
    b_hi_we = 1'b0; b_hi_wdata = '0;
    b_lo_we = 1'b0; b_lo_wdata = '0;
  endtask

  // Commit the current inputs to the model, then clock the DUT.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_hi = '0;
      m_lo = '0;
    end else begin
      if (b_rf_we && b_waddr != 0) m_regs[b_waddr] = b_wdata;
      if (b_hi_we) m_hi = b_hi_wdata;
      if (b_lo_we) m_lo = b_lo_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!rst && b_rf_we && b_waddr == a) return b_wdata;
`endif
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_hi();
`ifdef REGFILE_BYPASS_EN
    if (!rst && b_hi_we) return b_hi_wdata;
`endif
    return m_hi;
  endfunction

  function automatic logic [31:0] exp_lo();
`ifdef REGFILE_BYPASS_EN
    if (!rst && b_lo_we) return b_lo_wdata;
`endif
    return m_lo;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 'x;
    m_hi = 'x;
    m_lo = 'x;
    rst = 1'b1;
    raddr1 = 5'd5;
    raddr2 = 5'd0;
    bus_idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("reset_rdata1", rdata1, 32'h0);
    check_eq("reset_hi", hi_rdata, 32'h0);
    check_eq("reset_lo", lo_rdata, 32'h0);

    // 1: write r5, then reset clears it
    b_rf_we = 1'b1; b_waddr = 5'd5; b_wdata = 32'hDEADBEEF;
    tick();
    bus_idle();
    #1;
    check_eq("r5_written", rdata1, 32'hDEADBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("r5_after_reset", rdata1, 32'h0);
    check_eq("hi_after_reset", hi_rdata, 32'h0);
    check_eq("lo_after_reset", lo_rdata, 32'h0);

    // 2: dual read of same register, r0 write ignored
    b_rf_we = 1'b1; b_waddr = 5'd7; b_wdata = 32'h12345678;
    tick();
    bus_idle();
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    check_eq("r7_port1", rdata1, 32'h12345678);
    check_eq("r7_port2", rdata2, 32'h12345678);
    b_rf_we = 1'b1; b_waddr = 5'd0; b_wdata = 32'hFFFFFFFF;
    raddr1 = 5'd0; raddr2 = 5'd0;
    tick();
    bus_idle();
    #1;
    check_eq("r0_port1", rdata1, 32'h0);
    check_eq("r0_port2", rdata2, 32'h0);

    // 3: GPR + HI + LO in one beat
    b_rf_we = 1'b1; b_waddr = 5'd3; b_wdata = 32'hA5A5A5A5;
    b_hi_we = 1'b1; b_hi_wdata = 32'h1;
    b_lo_we = 1'b1; b_lo_wdata = 32'h2;
    tick();
    bus_idle();
    raddr1 = 5'd3; raddr2 = 5'd7;
    #1;
    check_eq("beat_r3", rdata1, 32'hA5A5A5A5);
    check_eq("beat_r7_kept", rdata2, 32'h12345678);
    check_eq("beat_hi", hi_rdata, 32'h1);
    check_eq("beat_lo", lo_rdata, 32'h2);

    // 4: HI-only write; LO data bits are don't-care
    b_hi_we = 1'b1; b_hi_wdata = 32'hCAFE0000;
    b_lo_we = 1'b0; b_lo_wdata = 32'h0000FFFF;
    b_rf_we = 1'b0; b_waddr = 5'd3; b_wdata = 32'h0BADF00D;
    tick();
    bus_idle();
    #1;
    check_eq("mthi_hi", hi_rdata, 32'hCAFE0000);
    check_eq("mthi_lo_kept", lo_rdata, 32'h2);
    check_eq("disabled_rf_write", rdata1, 32'hA5A5A5A5);

    // 5: same-cycle read of a register being written
    raddr1 = 5'd9; raddr2 = 5'd3;
    b_rf_we = 1'b1; b_waddr = 5'd9; b_wdata = 32'h55;
    b_hi_we = 1'b1; b_hi_wdata = 32'h1234;
    b_lo_we = 1'b1; b_lo_wdata = 32'h5678;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_eq("same_cycle_r9", rdata1, 32'h55);
    check_eq("same_cycle_hi", hi_rdata, 32'h1234);
    check_eq("same_cycle_lo", lo_rdata, 32'h5678);
`else
    check_eq("same_cycle_r9", rdata1, 32'h0);
    check_eq("same_cycle_hi", hi_rdata, 32'hCAFE0000);
    check_eq("same_cycle_lo", lo_rdata, 32'h2);
`endif
    check_eq("same_cycle_other_port", rdata2, 32'hA5A5A5A5);
    tick();
    bus_idle();
    #1;
    check_eq("next_cycle_r9", rdata1, 32'h55);
    check_eq("next_cycle_hi", hi_rdata, 32'h1234);
    check_eq("next_cycle_lo", lo_rdata, 32'h5678);

    // 6: write during reset is dropped and never bypassed
    b_rf_we = 1'b1; b_waddr = 5'd4; b_wdata = 32'h11;
    tick();
    raddr1 = 5'd4; raddr2 = 5'd9;
    rst = 1'b1;
    b_wdata = 32'h77;
    b_hi_we = 1'b1; b_hi_wdata = 32'h99;
    #1;
    check_eq("rst_no_bypass_r4", rdata1, 32'h11);
    check_eq("rst_no_bypass_hi", hi_rdata, 32'h1234);
    tick();
    rst = 1'b0;
    bus_idle();
    #1;
    check_eq("rst_write_dropped_r4", rdata1, 32'h0);
    check_eq("rst_cleared_r9", rdata2, 32'h0);
    check_eq("rst_write_dropped_hi", hi_rdata, 32'h0);

    // Random traffic against the model (model is fully known after the reset above)
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      b_rf_we    = $urandom_range(0, 1);
      b_waddr    = 5'($urandom_range(0, 31));
      b_wdata    = $urandom;
      b_hi_we    = ($urandom_range(0, 3) == 0);
      b_hi_wdata = $urandom;
      b_lo_we    = ($urandom_range(0, 3) == 0);
      b_lo_wdata = $urandom;
      raddr1     = ($urandom_range(0, 3) == 0) ? b_waddr : 5'($urandom_range(0, 31));
      raddr2     = 5'($urandom_range(0, 31));
      #1;
      check_eq("rand_rdata1", rdata1, exp_rd(raddr1));
      check_eq("rand_rdata2", rdata2, exp_rd(raddr2));
      check_eq("rand_hi", hi_rdata, exp_hi());
      check_eq("rand_lo", lo_rdata, exp_lo());
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
